// File: rtl/pc_redirect_unit_pkg.sv
// Shared definitions for the PC redirect unit.
//   pc_sel_e : encodings of the pc_sel input from the branch logic
//   state_e  : fetch control states
//   PC_STEP  : sequential fetch increment
package pc_redirect_unit_pkg;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_TRAP = 2'd2
  } state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_redirect_unit_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock
//   clr   : synchronous clear (highest priority)
//   inc   : increment request; ignored once the count is all-ones
//   count : current count
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// PC redirect unit: holds the fetch PC, drives the instruction-memory
// request handshake, and applies branch/jump redirects with pipeline flush.
//   clk           : clock, all state on rising edge
//   reset         : synchronous, active-low
//   pc_sel        : 0 seq, 1 branch, 2 jump, 3 treated as seq
//   branch_target : PC-relative target from EX
//   jump_target   : jump target from the ALU
//   stall         : load-use hold
//   imem_ready    : instruction memory accepts imem_addr this cycle
//   imem_req      : fetch request
//   imem_addr     : fetch address (= pc)
//   pc, pc_plus4  : current fetch PC and PC+4
//   fetch_valid   : IF/ID captures the fetched instruction this cycle
//   flush         : clear IF/ID and ID/EX at the next edge
//   misaligned    : sticky trap flag for a non-word-aligned redirect target
//   redirect_cnt  : saturating count of aligned redirects taken
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       pc_sel,
  input  logic [31:0]      branch_target,
  input  logic [31:0]      jump_target,
  input  logic             stall,
  input  logic             imem_ready,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             fetch_valid,
  output logic             flush,
  output logic             misaligned,
  output logic [CNT_W-1:0] redirect_cnt
);

  state_e      state_q;
  logic [31:0] pc_q;
  logic        misaligned_q;

  logic        redirect_sel;
  logic        accepted;
  logic [31:0] target;
  logic        target_aligned;

  always_comb begin
    redirect_sel = 1'b0;
    target       = branch_target;
    case (pc_sel)
      SEL_BRANCH: begin
        redirect_sel = 1'b1;
        target       = branch_target;
      end
      SEL_JUMP: begin
        redirect_sel = 1'b1;
        target       = jump_target;
      end
      default: begin
        redirect_sel = 1'b0;
        target       = branch_target;
      end
    endcase
  end

  // A redirect is ignored while in reset or trapped; flush follows it directly.
  assign accepted       = reset && redirect_sel && (state_q != ST_TRAP);
  assign target_aligned = (target[1:0] == 2'b00);

  assign imem_req    = reset && (state_q != ST_TRAP);
  assign fetch_valid = imem_req && !accepted && !stall && imem_ready;
  assign flush       = accepted;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + PC_STEP;
  assign misaligned  = misaligned_q;

  // Priority: reset > redirect > trap hold > stall > memory handshake.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q         <= RESET_VECTOR;
      state_q      <= ST_RUN;
      misaligned_q <= 1'b0;
    end else if (accepted) begin
      if (target_aligned) begin
        pc_q    <= target;
        state_q <= ST_RUN;
      end else begin
        misaligned_q <= 1'b1;
        state_q      <= ST_TRAP;
      end
    end else if (state_q == ST_TRAP || stall) begin
      state_q <= state_q;
    end else if (imem_ready) begin
      pc_q    <= pc_q + PC_STEP;
      state_q <= ST_RUN;
    end else begin
      state_q <= ST_WAIT;
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_redirect_cnt (
    .clk  (clk),
    .clr  (!reset),
    .inc  (accepted && target_aligned),
    .count(redirect_cnt)
  );

endmodule

// File: tb/tb_pc_redirect_unit.sv
module tb_pc_redirect_unit;
  import pc_redirect_unit_pkg::*;

  localparam int CNT_W = 2;

  logic             clk;
  logic             reset;
  logic [1:0]       pc_sel;
  logic [31:0]      branch_target;
  logic [31:0]      jump_target;
  logic             stall;
  logic             imem_ready;
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic [31:0]      pc;
  logic [31:0]      pc_plus4;
  logic             fetch_valid;
  logic             flush;
  logic             misaligned;
  logic [CNT_W-1:0] redirect_cnt;

  int errors = 0;
  int checks = 0;

  pc_redirect_unit #(
    .RESET_VECTOR(32'h0000_0000),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_sel       (pc_sel),
    .branch_target(branch_target),
    .jump_target  (jump_target),
    .stall        (stall),
    .imem_ready   (imem_ready),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .fetch_valid  (fetch_valid),
    .flush        (flush),
    .misaligned   (misaligned),
    .redirect_cnt (redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b0;
    pc_sel        = 2'd1;
    branch_target = 32'h0000_0700;
    jump_target   = 32'h0;
    stall         = 1'b0;
    imem_ready    = 1'b1;
    tick();
    tick();
    // reset state, redirect requested but ignored
    check("rst_pc", pc, 32'h0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_fv", 32'(fetch_valid), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_mis", 32'(misaligned), 32'd0);
    check("rst_cnt", 32'(redirect_cnt), 32'd0);

    // sequential fetch 0,4,8
    reset  = 1'b1;
    pc_sel = 2'd0;
    #1;
    check("seq0_req", 32'(imem_req), 32'd1);
    check("seq0_addr", imem_addr, 32'h0);
    check("seq0_fv", 32'(fetch_valid), 32'd1);
    tick();
    check("seq1_addr", imem_addr, 32'h4);
    check("seq1_fv", 32'(fetch_valid), 32'd1);
    tick();
    check("seq2_addr", imem_addr, 32'h8);
    check("seq2_fv", 32'(fetch_valid), 32'd1);
    check("seq2_plus4", pc_plus4, 32'hC);

    // memory not ready for two cycles at 0x8
    imem_ready = 1'b0;
    #1;
    check("nr_fv", 32'(fetch_valid), 32'd0);
    tick();
    check("wait_state", 32'(dut.state_q), 32'(ST_WAIT));
    check("wait_addr1", imem_addr, 32'h8);
    check("wait_req", 32'(imem_req), 32'd1);
    tick();
    check("wait_addr2", imem_addr, 32'h8);
    imem_ready = 1'b1;
    #1;
    check("wait_done_fv", 32'(fetch_valid), 32'd1);
    tick();
    check("wait_done_pc", pc, 32'hC);
    check("wait_done_state", 32'(dut.state_q), 32'(ST_RUN));

    // branch to 0x100, then branch 0x100 -> 0x40
    pc_sel        = 2'd1;
    branch_target = 32'h100;
    #1;
    check("br1_flush", 32'(flush), 32'd1);
    check("br1_fv", 32'(fetch_valid), 32'd0);
    tick();
    check("br1_pc", pc, 32'h100);
    check("br1_cnt", 32'(redirect_cnt), 32'd1);
    branch_target = 32'h40;
    #1;
    check("br2_flush", 32'(flush), 32'd1);
    tick();
    check("br2_pc", pc, 32'h40);
    check("br2_plus4", pc_plus4, 32'h44);
    check("br2_cnt", 32'(redirect_cnt), 32'd2);

    // plain stall holds the PC
    pc_sel = 2'd0;
    stall  = 1'b1;
    #1;
    check("stall_fv", 32'(fetch_valid), 32'd0);
    check("stall_req", 32'(imem_req), 32'd1);
    check("stall_flush", 32'(flush), 32'd0);
    tick();
    check("stall_pc", pc, 32'h40);

    // jump during stall wins
    pc_sel      = 2'd2;
    jump_target = 32'h200;
    #1;
    check("sj_flush", 32'(flush), 32'd1);
    tick();
    check("sj_pc", pc, 32'h200);
    check("sj_cnt", 32'(redirect_cnt), 32'd3);
    stall = 1'b0;

    // fourth redirect saturates the 2-bit counter
    jump_target = 32'h300;
    tick();
    check("sat_pc", pc, 32'h300);
    check("sat_cnt", 32'(redirect_cnt), 32'd3);

    // enter WAIT, then a redirect abandons the pending fetch
    pc_sel     = 2'd0;
    imem_ready = 1'b0;
    tick();
    check("w2_state", 32'(dut.state_q), 32'(ST_WAIT));
    pc_sel        = 2'd1;
    branch_target = 32'h500;
    imem_ready    = 1'b1;
    #1;
    check("wr_flush", 32'(flush), 32'd1);
    check("wr_fv", 32'(fetch_valid), 32'd0);
    tick();
    check("wr_pc", pc, 32'h500);
    check("wr_state", 32'(dut.state_q), 32'(ST_RUN));

    // pc_sel=3 behaves as sequential
    pc_sel = 2'd3;
    #1;
    check("sel3_flush", 32'(flush), 32'd0);
    tick();
    check("sel3_pc", pc, 32'h504);

    // wrap at the top of the address space
    pc_sel      = 2'd2;
    jump_target = 32'hFFFF_FFFC;
    tick();
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_plus4", pc_plus4, 32'h0);
    pc_sel = 2'd0;
    tick();
    check("wrap_next", pc, 32'h0);

    // reset in the middle of WAIT, overriding a redirect
    pc_sel      = 2'd2;
    jump_target = 32'h80;
    tick();
    pc_sel     = 2'd0;
    imem_ready = 1'b0;
    tick();
    check("rw_state", 32'(dut.state_q), 32'(ST_WAIT));
    check("rw_addr", imem_addr, 32'h80);
    reset         = 1'b0;
    pc_sel        = 2'd1;
    branch_target = 32'h600;
    #1;
    check("rw_flush", 32'(flush), 32'd0);
    check("rw_req", 32'(imem_req), 32'd0);
    tick();
    check("rw_pc", pc, 32'h0);
    check("rw_cnt", 32'(redirect_cnt), 32'd0);
    check("rw_state2", 32'(dut.state_q), 32'(ST_RUN));

    // misaligned branch traps
    reset      = 1'b1;
    pc_sel     = 2'd0;
    imem_ready = 1'b1;
    tick();
    check("pre_trap_pc", pc, 32'h4);
    pc_sel        = 2'd1;
    branch_target = 32'h42;
    #1;
    check("mis_flush", 32'(flush), 32'd1);
    tick();
    check("mis_pc", pc, 32'h4);
    check("mis_flag", 32'(misaligned), 32'd1);
    check("mis_state", 32'(dut.state_q), 32'(ST_TRAP));
    check("mis_req", 32'(imem_req), 32'd0);
    check("mis_cnt", 32'(redirect_cnt), 32'd0);
    pc_sel      = 2'd2;
    jump_target = 32'h100;
    #1;
    check("trap_flush", 32'(flush), 32'd0);
    check("trap_fv", 32'(fetch_valid), 32'd0);
    tick();
    check("trap_pc", pc, 32'h4);
    check("trap_flag", 32'(misaligned), 32'd1);
    pc_sel = 2'd0;
    tick();
    check("trap_pc2", pc, 32'h4);

    // only reset leaves TRAP
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("exit_mis", 32'(misaligned), 32'd0);
    check("exit_pc", pc, 32'h0);
    check("exit_req", 32'(imem_req), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
